lcd_status_writer: RTL and testbench

- Parametrised successor to the single-shot LCD text sequencer for the elevator project.
- Runs the HD44780 init sequence once after reset, then draws a 2x16 status screen: line 1 shows the movement state, line 2 shows the floor number.
- Redraws automatically whenever the movement state or floor changes.
- Sits between the elevator controller and the existing LCD_Controller, and drives it through the iStart/oDone handshake.

---
 rtl/lcd_status_writer_if.sv | 13 +
 rtl/lcd_status_writer.sv | 223 ++++++++++++++++++++++
 tb/tb_lcd_status_writer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_status_writer_if.sv
// Bus between the status writer and the LCD_Controller: one byte plus
// register select, qualified by a start/done handshake.
interface lcd_status_writer_if;
  logic [7:0] oDATA;
  logic       oRS;
  logic       oStart;
  logic       iDone;

  // Writer side: issues bytes and waits for completion.
  modport master (output oDATA, output oRS, output oStart, input iDone);
  // LCD_Controller side: consumes bytes and reports completion.
  modport slave  (input oDATA, input oRS, input oStart, output iDone);
endinterface

// File: rtl/lcd_status_writer.sv
// Elevator status screen writer for a 2x16 HD44780 display.
// Runs the display init sequence once after reset, then draws the movement
// state on line 1 and the floor number on line 2, redrawing whenever either
// input differs from the values shown by the last completed frame.
module lcd_status_writer #(
  parameter int                 DLY_W      = 18,
  parameter logic [DLY_W-1:0]   DLY_CYCLES = 18'h3FFFE,
  parameter int                 FLOOR_W    = 4,
  parameter int                 MAX_FLOOR  = 15
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic [1:0]            iMOVE,
  input  logic [FLOOR_W-1:0]    iFLOOR,
  lcd_status_writer_if.master   lcd,
  output logic                  oBusy,
  output logic                  oFrameDone
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    DELAY = 3'd3,
    NEXT  = 3'd4
  } stateT;

  // Entry numbering follows the init frame; a redraw frame starts at the
  // DDRAM-home command and shares every later entry.
  localparam logic [5:0] IDX_REDRAW = 6'd4;
  localparam logic [5:0] IDX_LINE1  = 6'd5;
  localparam logic [5:0] IDX_CMD2   = 6'd21;
  localparam logic [5:0] IDX_LINE2  = 6'd22;
  localparam logic [5:0] IDX_LAST   = 6'd37;

  localparam logic [DLY_W-1:0] DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_CYCLES - DLY_ONE;
  // One spare bit so the range check never collapses to a constant.
  localparam logic [FLOOR_W:0] MAX_FW   = (FLOOR_W+1)'(MAX_FLOOR);

  localparam logic [127:0] TXT_PARADO   = {"Parado _",   {8{8'h20}}};
  localparam logic [127:0] TXT_SUBINDO  = {"Subindo +",  {7{8'h20}}};
  localparam logic [127:0] TXT_DESCENDO = {"Descendo -", {6{8'h20}}};
  localparam logic [127:0] TXT_ERRO     = {"Erro",       {12{8'h20}}};

  // Character at column pos of a 16-character line (column 0 is leftmost).
  function automatic logic [7:0] pickChar(input logic [127:0] txt, input logic [3:0] pos);
    pickChar = txt[{4'd15 - pos, 3'b000} +: 8];
  endfunction

  function automatic logic [127:0] line1Text(input logic [1:0] mv);
    case (mv)
      2'd0:    line1Text = TXT_PARADO;
      2'd1:    line1Text = TXT_SUBINDO;
      2'd2:    line1Text = TXT_DESCENDO;
      2'd3:    line1Text = TXT_ERRO;
      default: line1Text = TXT_ERRO;
    endcase
  endfunction

  // Two ASCII digits by repeated compare/subtract, or "--" when out of range.
  function automatic logic [15:0] floorDigits(input logic [FLOOR_W-1:0] fl);
    logic [FLOOR_W-1:0] rem;
    logic [3:0]         tens;
    rem  = fl;
    tens = 4'd0;
    if ({1'b0, fl} > MAX_FW) begin
      floorDigits = "--";
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (rem >= FLOOR_W'(8'd10)) begin
          rem  = rem - FLOOR_W'(8'd10);
          tens = tens + 4'd1;
        end else begin
          rem  = rem;
        end
      end
      floorDigits = {8'h30 + {4'd0, tens}, 8'h30 + {4'd0, 4'(rem)}};
    end
  endfunction

  function automatic logic [127:0] line2Text(input logic [FLOOR_W-1:0] fl);
    line2Text = {"Andar ", floorDigits(fl), {8{8'h20}}};
  endfunction

  // {RS, byte} for a frame entry, built from the snapshot.
  function automatic logic [8:0] entryAt(input logic [5:0] idx, input logic [1:0] mv,
                                         input logic [FLOOR_W-1:0] fl);
    case (idx)
      6'd0:       entryAt = 9'h038;
      6'd1:       entryAt = 9'h00C;
      6'd2:       entryAt = 9'h001;
      6'd3:       entryAt = 9'h006;
      IDX_REDRAW: entryAt = 9'h080;
      IDX_CMD2:   entryAt = 9'h0C0;
      default: begin
        if (idx >= IDX_LINE1 && idx < IDX_CMD2) begin
          entryAt = {1'b1, pickChar(line1Text(mv), 4'(idx - IDX_LINE1))};
        end else if (idx >= IDX_LINE2 && idx <= IDX_LAST) begin
          entryAt = {1'b1, pickChar(line2Text(fl), 4'(idx - IDX_LINE2))};
        end else begin
          entryAt = 9'h000;
        end
      end
    endcase
  endfunction

  stateT              stateR, stateNxt;
  logic [5:0]         idxR, idxNxt;
  logic [DLY_W-1:0]   dlyR, dlyNxt;
  logic               initDoneR, initDoneNxt;
  logic [1:0]         snapMoveR, snapMoveNxt;
  logic [FLOOR_W-1:0] snapFloorR, snapFloorNxt;
  logic [7:0]         dataR, dataNxt;
  logic               rsR, rsNxt;
  logic               startR, startNxt;
  logic               busyR, busyNxt;
  logic               frameDoneR, frameDoneNxt;
  logic [8:0]         curEntry;

  assign curEntry = entryAt(idxR, snapMoveR, snapFloorR);

  // Next-state and next-output decisions for the frame sequencer.
  always_comb begin
    stateNxt     = stateR;
    idxNxt       = idxR;
    dlyNxt       = dlyR;
    initDoneNxt  = initDoneR;
    snapMoveNxt  = snapMoveR;
    snapFloorNxt = snapFloorR;
    dataNxt      = dataR;
    rsNxt        = rsR;
    startNxt     = startR;
    busyNxt      = busyR;
    frameDoneNxt = 1'b0;
    case (stateR)
      IDLE: begin
        if (!initDoneR || (iMOVE != snapMoveR) || (iFLOOR != snapFloorR)) begin
          snapMoveNxt  = iMOVE;
          snapFloorNxt = iFLOOR;
          busyNxt      = 1'b1;
          idxNxt       = initDoneR ? IDX_REDRAW : 6'd0;
          stateNxt     = LOAD;
        end else begin
          stateNxt = IDLE;
        end
      end
      LOAD: begin
        {rsNxt, dataNxt} = curEntry;
        startNxt         = 1'b1;
        stateNxt         = WAIT;
      end
      WAIT: begin
        if (lcd.iDone) begin
          startNxt = 1'b0;
          stateNxt = DELAY;
        end else begin
          startNxt = 1'b1;
        end
      end
      DELAY: begin
        if (dlyR == DLY_LAST) begin
          dlyNxt   = {DLY_W{1'b0}};
          stateNxt = NEXT;
        end else begin
          dlyNxt = dlyR + DLY_ONE;
        end
      end
      NEXT: begin
        if (idxR == IDX_LAST) begin
          initDoneNxt  = 1'b1;
          busyNxt      = 1'b0;
          frameDoneNxt = 1'b1;
          stateNxt     = IDLE;
        end else begin
          idxNxt   = idxR + 6'd1;
          stateNxt = LOAD;
        end
      end
      default: begin
        stateNxt = IDLE;
        busyNxt  = 1'b0;
        startNxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateR     <= IDLE;
      idxR       <= 6'd0;
      dlyR       <= {DLY_W{1'b0}};
      initDoneR  <= 1'b0;
      snapMoveR  <= 2'd0;
      snapFloorR <= {FLOOR_W{1'b0}};
      dataR      <= 8'h00;
      rsR        <= 1'b0;
      startR     <= 1'b0;
      busyR      <= 1'b0;
      frameDoneR <= 1'b0;
    end else begin
      stateR     <= stateNxt;
      idxR       <= idxNxt;
      dlyR       <= dlyNxt;
      initDoneR  <= initDoneNxt;
      snapMoveR  <= snapMoveNxt;
      snapFloorR <= snapFloorNxt;
      dataR      <= dataNxt;
      rsR        <= rsNxt;
      startR     <= startNxt;
      busyR      <= busyNxt;
      frameDoneR <= frameDoneNxt;
    end
  end

  assign lcd.oDATA  = dataR;
  assign lcd.oRS    = rsR;
  assign lcd.oStart = startR;
  assign oBusy      = busyR;
  assign oFrameDone = frameDoneR;

endmodule

// File: tb/tb_lcd_status_writer.sv
// Bench for lcd_status_writer: a frame-level model predicts the byte stream
// from the displayed text, a responder plays the LCD_Controller handshake.
module tb_lcd_status_writer;

  localparam int DLYC = 4;
  localparam int MAXF = 12;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [1:0] iMOVE;
  logic [3:0] iFLOOR;
  logic       oBusy;
  logic       oFrameDone;

  lcd_status_writer_if lcdIf ();

  lcd_status_writer #(
    .DLY_W(18), .DLY_CYCLES(18'd4), .FLOOR_W(4), .MAX_FLOOR(12)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iMOVE(iMOVE), .iFLOOR(iFLOOR),
    .lcd(lcdIf), .oBusy(oBusy), .oFrameDone(oFrameDone)
  );

  always #5 iCLK = ~iCLK;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state
  logic [8:0] expQ[$];
  logic [8:0] curLog[$];
  logic [8:0] lastLog[$];
  bit         mInit = 1'b0;
  bit         inFrame = 1'b0;
  bit         trigPrev = 1'b0;
  logic [1:0] shownMove = 2'd0, snapMove = 2'd0, prevMove = 2'd0;
  logic [3:0] shownFloor = 4'd0, snapFloor = 4'd0, prevFloor = 4'd0;
  logic       prevStart = 1'b0, prevDone = 1'b0;
  logic [8:0] prevEntry = 9'h000;
  int         lowCnt = 100;
  int         frameCount = 0;
  bit         stall = 1'b0;
  bit         fixedLat = 1'b1;

  function automatic string padTo16(input string s);
    string r;
    r = s;
    while (r.len() < 16) r = {r, " "};
    return r;
  endfunction

  // Expected byte stream of one frame, straight from the displayed text.
  function automatic void buildFrame(input bit withInit, input logic [1:0] mv, input int fl);
    string l1, l2;
    if (withInit) begin
      expQ.push_back(9'h038); expQ.push_back(9'h00C);
      expQ.push_back(9'h001); expQ.push_back(9'h006);
    end
    expQ.push_back(9'h080);
    case (mv)
      2'd0:    l1 = "Parado _";
      2'd1:    l1 = "Subindo +";
      2'd2:    l1 = "Descendo -";
      default: l1 = "Erro";
    endcase
    l2 = (fl > MAXF) ? "Andar --" : $sformatf("Andar %02d", fl);
    l1 = padTo16(l1);
    l2 = padTo16(l2);
    for (int i = 0; i < 16; i++) expQ.push_back({1'b1, l1[i]});
    expQ.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) expQ.push_back({1'b1, l2[i]});
  endfunction

  // Compare process: checks handshake, busy, frame-done and every transfer.
  always @(negedge iCLK) begin
    logic [8:0] cur;
    logic       rise;
    cur  = {lcdIf.oRS, lcdIf.oDATA};
    rise = lcdIf.oStart && !prevStart;
    if (!iRST_N) begin
      mInit = 1'b0; inFrame = 1'b0; trigPrev = 1'b0;
      expQ.delete(); curLog.delete(); lowCnt = 100;
    end else begin
      if (!inFrame) begin
        chk("busy_vs_trigger", oBusy, trigPrev);
        if (trigPrev) begin
          inFrame = 1'b1; snapMove = prevMove; snapFloor = prevFloor;
          buildFrame(!mInit, snapMove, int'(snapFloor));
        end
      end
      if (prevStart) chk("start_until_done", lcdIf.oStart, !prevDone);
      if (!rise) chk("data_stable", cur, prevEntry);
      if (rise) begin
        chk("transfer_expected", (inFrame && expQ.size() != 0), 1);
        if (inFrame && expQ.size() != 0) chk("entry", cur, expQ.pop_front());
        chk("start_gap_min", (lowCnt >= DLYC + 2), 1);
        curLog.push_back(cur);
      end
      if (oFrameDone) begin
        chk("frame_done_in_frame", inFrame, 1);
        chk("frame_done_all_sent", expQ.size(), 0);
        chk("busy_low_at_done", oBusy, 0);
        inFrame = 1'b0; mInit = 1'b1;
        shownMove = snapMove; shownFloor = snapFloor;
        lastLog = curLog; curLog.delete();
        frameCount++;
      end else if (inFrame) begin
        chk("busy_in_frame", oBusy, 1);
      end
      lowCnt   = lcdIf.oStart ? 0 : lowCnt + 1;
      trigPrev = !inFrame && (!mInit || iMOVE != shownMove || iFLOOR != shownFloor);
      prevMove  = iMOVE;
      prevFloor = iFLOOR;
    end
    prevStart = lcdIf.oStart;
    prevDone  = lcdIf.iDone;
    prevEntry = cur;
  end

  // LCD_Controller stand-in: raises iDone for one cycle some cycles after oStart.
  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = 3;
    lcdIf.iDone = 1'b0;
    forever begin
      @(posedge iCLK);
      #1;
      if (!iRST_N) begin
        lcdIf.iDone = 1'b0; cnt = 0;
      end else if (lcdIf.iDone) begin
        lcdIf.iDone = 1'b0;
      end else if (lcdIf.oStart && !stall) begin
        cnt++;
        if (cnt >= lat) begin
          lcdIf.iDone = 1'b1;
          cnt = 0;
          lat = fixedLat ? 3 : int'($urandom_range(1, 4));
        end
      end
    end
  end

  task automatic setIn(input logic [1:0] mv, input logic [3:0] fl);
    @(posedge iCLK);
    #1;
    iMOVE  = mv;
    iFLOOR = fl;
  endtask

  task automatic waitFrames(input int n, input string nm);
    int target;
    int t;
    target = frameCount + n;
    t = 0;
    while (frameCount < target && t < 20000) begin
      @(posedge iCLK);
      t++;
    end
    #1;
    chk(nm, (frameCount >= target), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sz;
    int t;
    int quiet;
    iRST_N = 1'b0; iMOVE = 2'd0; iFLOOR = 4'd0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_data", lcdIf.oDATA, 0);
    chk("rst_rs", lcdIf.oRS, 0);
    chk("rst_start", lcdIf.oStart, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_frame_done", oFrameDone, 0);
    iRST_N = 1'b1;

    // Init frame with fixed 3-cycle responder
    waitFrames(1, "init_frame_wait");
    chk("init_len", lastLog.size(), 38);
    chk("init_0", lastLog[0], 9'h038);
    chk("init_1", lastLog[1], 9'h00C);
    chk("init_2", lastLog[2], 9'h001);
    chk("init_3", lastLog[3], 9'h006);
    chk("init_4", lastLog[4], 9'h080);
    chk("init_P", lastLog[5], 9'h150);
    chk("init_underscore", lastLog[12], 9'h15F);
    chk("init_pad", lastLog[13], 9'h120);
    chk("init_line2_cmd", lastLog[21], 9'h0C0);
    chk("init_A", lastLog[22], 9'h141);
    chk("init_tens", lastLog[28], 9'h130);
    chk("init_ones", lastLog[29], 9'h130);
    fixedLat = 1'b0;

    // Redraw: moving up, floor 12 (boundary: equals MAX_FLOOR)
    setIn(2'd1, 4'd12);
    waitFrames(1, "redraw12_wait");
    chk("r12_len", lastLog.size(), 34);
    chk("r12_first", lastLog[0], 9'h080);
    chk("r12_S", lastLog[1], 9'h153);
    chk("r12_plus", lastLog[9], 9'h12B);
    chk("r12_cmd2", lastLog[17], 9'h0C0);
    chk("r12_tens", lastLog[24], 9'h131);
    chk("r12_ones", lastLog[25], 9'h132);

    // Changes during a frame: 3 drawn, 4 dropped, 5 drawn once
    setIn(2'd1, 4'd3);
    t = 0;
    while (!oBusy && t < 100) begin @(posedge iCLK); t++; end
    base = frameCount;
    repeat (30) @(posedge iCLK);
    setIn(2'd1, 4'd4);
    repeat (30) @(posedge iCLK);
    setIn(2'd1, 4'd5);
    waitFrames(2, "coalesce_wait");
    repeat (300) @(posedge iCLK);
    #1;
    chk("coalesce_frames", frameCount, base + 2);
    chk("coalesce_tens", lastLog[24], 9'h130);
    chk("coalesce_ones", lastLog[25], 9'h135);

    // Out-of-range floor
    setIn(2'd2, 4'd13);
    waitFrames(1, "dash_wait");
    chk("dash_D", lastLog[1], 9'h144);
    chk("dash_minus", lastLog[10], 9'h12D);
    chk("dash_tens", lastLog[24], 9'h12D);
    chk("dash_ones", lastLog[25], 9'h12D);

    // Error state, floor 10
    setIn(2'd3, 4'd10);
    waitFrames(1, "erro_wait");
    chk("erro_E", lastLog[1], 9'h145);
    chk("erro_o", lastLog[4], 9'h16F);
    chk("erro_pad", lastLog[5], 9'h120);
    chk("erro_tens", lastLog[24], 9'h131);
    chk("erro_ones", lastLog[25], 9'h130);

    // Random input changes at random times
    for (int k = 0; k < 8; k++) begin
      setIn(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      t = $urandom_range(0, 600);
      repeat (t) @(posedge iCLK);
    end
    t = 0; quiet = 0;
    while (quiet < 20 && t < 30000) begin
      @(posedge iCLK);
      t++;
      quiet = oBusy ? 0 : quiet + 1;
    end
    chk("random_settle", (quiet >= 20), 1);

    // Long iDone stall
    setIn(2'd0, 4'd7);
    t = 0;
    while (!(curLog.size() >= 5 && lcdIf.oStart && !lcdIf.iDone) && t < 5000) begin
      @(negedge iCLK);
      #1;
      t++;
    end
    chk("stall_reached", (t < 5000), 1);
    stall = 1'b1;
    sz = curLog.size();
    repeat (1000) @(posedge iCLK);
    #2;
    chk("stall_start_high", lcdIf.oStart, 1);
    chk("stall_no_advance", curLog.size(), sz);
    stall = 1'b0;
    waitFrames(1, "stall_resume");
    chk("stall_len", lastLog.size(), 34);

    // Reset while waiting on entry 20
    setIn(2'd2, 4'd9);
    t = 0;
    while (!(curLog.size() == 21 && lcdIf.oStart) && t < 5000) begin
      @(posedge iCLK);
      #1;
      t++;
    end
    chk("reach_entry20", curLog.size(), 21);
    chk("busy_before_reset", oBusy, 1);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("mid_rst_data", lcdIf.oDATA, 0);
    chk("mid_rst_rs", lcdIf.oRS, 0);
    chk("mid_rst_start", lcdIf.oStart, 0);
    chk("mid_rst_busy", oBusy, 0);
    chk("mid_rst_frame_done", oFrameDone, 0);
    repeat (3) @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
    waitFrames(1, "reinit_wait");
    chk("reinit_len", lastLog.size(), 38);
    chk("reinit_0", lastLog[0], 9'h038);
    chk("reinit_4", lastLog[4], 9'h080);
    chk("reinit_D", lastLog[5], 9'h144);
    chk("reinit_tens", lastLog[28], 9'h130);
    chk("reinit_ones", lastLog[29], 9'h139);

    repeat (20) @(posedge iCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
